// File: rtl/dot_product_param.sv
// rtl/dot_product_param.sv - parametrised signed dot-product engine with buffered operands
//
// Computes sum(A[i]*B[i]) for i < min(len, N), LANES products per cycle.
// Optional feature macro: DOTP_SAT_EN (saturate result to RES_W and raise sat).
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   wr_en/wr_sel    element write strobe; buffer select (0 = A, 1 = B)
//   wr_addr/wr_data element index and signed value (accepted only when idle)
//   start/len       start request and element count, sampled together
//   abort           cancels a run in progress
//   busy            high while running or finishing
//   done            sticky completion flag, cleared by the next accepted start
//   result          signed dot product
//   sat             result was clipped (always 0 without DOTP_SAT_EN)
module dot_product_param #(
  parameter int N     = 8,
  parameter int DW    = 32,
  parameter int LANES = 2,
  parameter int RES_W = 64,
  parameter int AW    = (N > 1) ? $clog2(N) : 1,
  parameter int LW    = $clog2(N + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic                    wr_sel,
  input  logic [AW-1:0]           wr_addr,
  input  logic signed [DW-1:0]    wr_data,
  input  logic                    start,
  input  logic [LW-1:0]           len,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic signed [RES_W-1:0] result,
  output logic                    sat
);

  // Wide enough for N full-scale products, so the running sum never wraps.
  localparam int ACC_W = 2 * DW + $clog2(N) + 1;
  // idx can step past the last element by up to LANES-1 before leaving RUN.
  localparam int IW = $clog2(N + LANES) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  state_t state, state_next;

  logic signed [DW-1:0]    a_mem [N];
  logic signed [DW-1:0]    b_mem [N];
  logic [LW-1:0]           l_reg;
  logic [IW-1:0]           idx;
  logic [IW-1:0]           lane_idx;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] lane_sum;
  logic signed [RES_W-1:0] fit_val;
  logic                    fit_sat;
  logic                    sat_q;
  logic [LW-1:0]           len_c;
  logic                    start_ok;
  logic                    last_step;

  assign len_c     = (int'(len) > N) ? LW'(N) : len;
  // abort in IDLE swallows a simultaneous start.
  assign start_ok  = (state == IDLE) && start && !abort;
  assign last_step = (int'(idx) + LANES) >= int'(l_reg);
  assign busy      = (state != IDLE);
  assign sat       = sat_q;

  // Lanes past the run length contribute nothing, so a partial final group is safe.
  always_comb begin
    lane_sum = '0;
    lane_idx = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_idx = idx + IW'(k);
      if (int'(lane_idx) < int'(l_reg))
        lane_sum = lane_sum + ACC_W'(a_mem[lane_idx[AW-1:0]]) * ACC_W'(b_mem[lane_idx[AW-1:0]]);
    end
  end

`ifdef DOTP_SAT_EN
  localparam int EXT_W = (ACC_W > RES_W) ? ACC_W : RES_W;
  logic signed [EXT_W-1:0] acc_ext;
  logic signed [EXT_W-1:0] res_max;
  logic signed [EXT_W-1:0] res_min;

  assign acc_ext = EXT_W'(acc);
  assign res_max = {{(EXT_W - RES_W + 1){1'b0}}, {(RES_W - 1){1'b1}}};
  assign res_min = ~res_max;

  always_comb begin
    fit_val = RES_W'(acc_ext);
    fit_sat = 1'b0;
    if (acc_ext > res_max) begin
      fit_val = res_max[RES_W-1:0];
      fit_sat = 1'b1;
    end else if (acc_ext < res_min) begin
      fit_val = res_min[RES_W-1:0];
      fit_sat = 1'b1;
    end
  end
`else
  assign fit_val = RES_W'(acc);
  assign fit_sat = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_ok) state_next = (len_c != '0) ? RUN : FINISH;
      RUN:     if (abort) state_next = IDLE;
               else if (last_step) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        a_mem[i] <= '0;
        b_mem[i] <= '0;
      end
      l_reg  <= '0;
      idx    <= '0;
      acc    <= '0;
      result <= '0;
      done   <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      if (state == IDLE && wr_en && int'(wr_addr) < N) begin
        if (wr_sel) b_mem[wr_addr] <= wr_data;
        else        a_mem[wr_addr] <= wr_data;
      end
      case (state)
        IDLE: begin
          if (start_ok) begin
            l_reg <= len_c;
            acc   <= '0;
            idx   <= '0;
            done  <= 1'b0;
            sat_q <= 1'b0;
          end
        end
        RUN: begin
          if (abort) begin
            done <= 1'b0;
          end else begin
            acc <= acc + lane_sum;
            idx <= idx + IW'(LANES);
          end
        end
        FINISH: begin
          // abort wins over the result update; the previous result is kept.
          if (abort) begin
            done <= 1'b0;
          end else begin
            result <= fit_val;
            done   <= 1'b1;
            sat_q  <= fit_sat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_param.sv
// tb/tb_dot_product_param.sv - directed table-driven bench for dot_product_param
module tb_dot_product_param;
  localparam int N = 8, DW = 32, RES_W = 64, AW = 3, LW = 4;
  localparam longint NEG31 = 64'shFFFF_FFFF_8000_0000;
  localparam longint MAX63 = 64'sh7FFF_FFFF_FFFF_FFFF;

  logic clk, rst, wr_en, wr_sel, start, abort;
  logic [AW-1:0] wr_addr;
  logic signed [DW-1:0] wr_data;
  logic [LW-1:0] len;
  logic busy0, done0, sat0, busy1, done1, sat1;
  logic signed [RES_W-1:0] result0, result1;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int     ak;
    longint av;
    int     bk;
    longint bv;
    int     l;
    longint exp_r;
    bit     exp_s;
    int     lat2;
    int     lat1;
  } vec_t;
  vec_t vt [9];

  dot_product_param #(.N(N), .DW(DW), .LANES(2), .RES_W(RES_W)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .len(len), .abort(abort),
    .busy(busy0), .done(done0), .result(result0), .sat(sat0));

  dot_product_param #(.N(N), .DW(DW), .LANES(1), .RES_W(RES_W)) u_dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .len(len), .abort(abort),
    .busy(busy1), .done(done1), .result(result1), .sat(sat1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic load(input bit sel, input int kind, input longint val);
    longint v;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      v       = (kind == 0) ? longint'(i + 1) : val;
      wr_en   = 1'b1;
      wr_sel  = sel;
      wr_addr = AW'(i);
      wr_data = v[DW-1:0];
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Latencies are counted in clock edges after the edge that accepts start.
  task automatic do_run(input int l, output int lat0, output int lat1, output int bcnt);
    int lv;
    lv = l;
    lat0 = -1; lat1 = -1; bcnt = 0;
    @(negedge clk);
    start = 1'b1;
    len   = lv[LW-1:0];
    @(posedge clk); #1;
    start = 1'b0;
    if (busy0) bcnt++;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      if (lat0 < 0 && done0) lat0 = cyc;
      if (lat1 < 0 && done1) lat1 = cyc;
      if (busy0) bcnt++;
      if (lat0 >= 0 && lat1 >= 0) break;
    end
  endtask

  initial begin
    int lat0, lat1, bcnt;
    longint big_r;
    bit big_s;
`ifdef DOTP_SAT_EN
    big_r = MAX63; big_s = 1'b1;
`else
    big_r = 0;     big_s = 1'b0;
`endif
    vt[0] = '{0, 0,     0, 0,     8,  204,   1'b0, 5, 9};
    vt[1] = '{1, -3,    1, 7,     8,  -168,  1'b0, 5, 9};
    vt[2] = '{0, 0,     1, 1,     3,  6,     1'b0, 3, 4};
    vt[3] = '{0, 0,     1, 1,     0,  0,     1'b0, 1, 1};
    vt[4] = '{0, 0,     1, 1,     12, 36,    1'b0, 5, 9};
    vt[5] = '{1, NEG31, 1, NEG31, 8,  big_r, big_s, 5, 9};
    vt[6] = '{0, 0,     0, 0,     1,  1,     1'b0, 2, 2};
    vt[7] = '{0, 0,     0, 0,     7,  140,   1'b0, 5, 8};
    vt[8] = '{1, 5,     1, -4,    5,  -100,  1'b0, 4, 6};

    rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; len = '0; abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", busy0, 0);
    chk("reset done", done0, 0);
    chk("reset result", result0, 0);
    chk("reset sat", sat0, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      load(1'b0, vt[i].ak, vt[i].av);
      load(1'b1, vt[i].bk, vt[i].bv);
      do_run(vt[i].l, lat0, lat1, bcnt);
      chk($sformatf("v%0d result", i), result0, vt[i].exp_r);
      chk($sformatf("v%0d sat", i), sat0, longint'(vt[i].exp_s));
      chk($sformatf("v%0d latency", i), lat0, vt[i].lat2);
      chk($sformatf("v%0d busy cycles", i), bcnt, vt[i].lat2);
      chk($sformatf("v%0d lanes1 result", i), result1, vt[i].exp_r);
      chk($sformatf("v%0d lanes1 sat", i), sat1, longint'(vt[i].exp_s));
      chk($sformatf("v%0d lanes1 latency", i), lat1, vt[i].lat1);
    end

    // Write and restart attempts while busy must be ignored.
    load(1'b0, 0, 0);
    load(1'b1, 0, 0);
    @(negedge clk);
    start = 1'b1; len = 4'd8;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = '0; wr_data = 32'sd100;
    start = 1'b1; len = 4'd3;
    @(posedge clk); #1;
    wr_en = 1'b0; start = 1'b0;
    lat0 = -1; lat1 = -1;
    for (int cyc = 2; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      if (lat0 < 0 && done0) lat0 = cyc;
      if (lat1 < 0 && done1) lat1 = cyc;
      if (lat0 >= 0 && lat1 >= 0) break;
    end
    chk("busy restart latency", lat0, 5);
    chk("busy restart result", result0, 204);
    chk("busy restart lanes1 latency", lat1, 9);
    do_run(8, lat0, lat1, bcnt);
    chk("rerun after busy write", result0, 204);
    chk("rerun after busy write lanes1", result1, 204);

    // abort together with start in IDLE: nothing happens.
    @(negedge clk);
    start = 1'b1; abort = 1'b1; len = 4'd8;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("idle abort busy", busy0, 0);
    chk("idle abort done", done0, 1);

    // abort mid-RUN.
    @(negedge clk);
    start = 1'b1; len = 4'd8;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort busy", busy0, 0);
    chk("abort done", done0, 0);
    chk("abort result kept", result0, 204);
    @(posedge clk); #1;
    chk("abort stays idle", busy0, 0);

    // reset mid-RUN clears everything, including the buffers.
    @(negedge clk);
    start = 1'b1; len = 4'd8;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrun reset busy", busy0, 0);
    chk("midrun reset done", done0, 0);
    chk("midrun reset result", result0, 0);
    chk("midrun reset sat", sat0, 0);
    @(negedge clk);
    rst = 1'b0;
    do_run(8, lat0, lat1, bcnt);
    chk("post reset result", result0, 0);
    chk("post reset latency", lat0, 5);
    chk("post reset lanes1 result", result1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dot_product_param.md
Name: dot_product_param

Overview:
Parametrised signed dot-product engine and the successor to the fixed 8-element, 1-MAC/cycle unit. Operand vectors A and B are loaded through an addressed write port into internal buffers, replacing one port per element. Computation uses LANES parallel multipliers over a runtime-selectable length. The block sits behind CSRs on the SoC bus; software polls busy/done and reads result.

Parameters:
N, 8, max vector length (buffer depth per operand), >=1
DW, 32, signed element width
LANES, 2, products summed per cycle; 1 <= LANES <= N
RES_W, 64, result output width; must be >= 2*DW
AW, $clog2(N) (min 1), element address width, derived
LW, $clog2(N+1), length field width, derived

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
wr_en  in  1  element write strobe
wr_sel  in  1  0 = A buffer, 1 = B buffer
wr_addr  in  AW  element index
wr_data  in  DW  signed element value
start  in  1  start request; level sampled
len  in  LW  element count for this run, sampled with start
abort  in  1  synchronous cancel of a run
busy  out  1  run in progress
done  out  1  sticky completion flag
result  out  RES_W  signed dot product
sat  out  1  result clipped (see optional feature)

Behaviour:
- Reset values: busy=0, done=0, result=0, sat=0, state=IDLE, both buffers cleared to 0. Reset mid-run discards the run.
- Writes: when wr_en=1 and state=IDLE, the selected buffer[wr_addr] is written at the clock edge. Writes are ignored when not IDLE or when wr_addr >= N. Buffers persist across runs.
- Internal accumulator: ACC_W = 2*DW + $clog2(N) + 1 bits, signed. It never overflows internally.
- States:
  - IDLE: on start=1, latch L = min(len, N), set acc=0, idx=0, done=0, sat=0. Go to RUN if L>0, otherwise go to FINISH.
  - RUN: busy=1. Each cycle, acc += sum over lanes k of A[idx+k]*B[idx+k], where any lane with idx+k >= L contributes 0. Then idx += LANES. When idx+LANES >= L, go to FINISH.
  - FINISH: result <= fit(acc); done <= 1; busy <= 0; go to IDLE.
- Latency: with G = ceil(L/LANES), done rises G+1 cycles after the start edge. For L=0, done rises 1 cycle after the start edge with result=0.
- done and result hold until the next accepted start, which clears done in the same edge it latches. start while busy is ignored.
- abort=1 in RUN or FINISH: go to IDLE, busy=0, done=0, result unchanged. abort has priority over the FINISH update. abort in IDLE has no effect; start is ignored in that cycle.
- len > N is clamped to N. len=0 is legal.
- busy is 1 in RUN and FINISH only.

Optional Feature:
Macro DOTP_SAT_EN.
- Defined: fit() saturates acc to the signed RES_W range, and sat=1 when clipping occurred.
- Undefined: fit() keeps the low RES_W bits (two's-complement wrap), and sat is tied to 0.

Test Plan:
- N=8, LANES=2: A=B=1..8, len=8 -> result=204, done 5 cycles after start, busy high 5 cycles.
- A=-3 all, B=7 all, len=8 -> result=-168; with LANES=1, done 9 cycles after start.
- A=1..8, B=1 all, len=3 -> result=6 (lanes beyond L masked), done 3 cycles after start; len=0 -> result=0, done after 1 cycle; len=12 -> treated as 8, result=36.
- A=B=-2^31 all, len=8 (sum 2^65): DOTP_SAT_EN defined -> result=2^63-1, sat=1; undefined -> result=0, sat=0.
- Write A[0]=100 while busy, then rerun with the original A=B=1..8 -> second result=204 (write ignored); start pulsed during busy -> no restart.
- Assert abort mid-RUN -> IDLE next cycle, done=0, result keeps the prior value. Assert rst mid-RUN -> all outputs 0 and buffers 0, so a subsequent len=8 run -> result=0.
